// File: rtl/pre_proc_pkg.sv
// +----------------------------------------------------------------------------+
// | pre_proc_pkg : shared types and constants for the G.729 pre-process HPF     |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

package pre_proc_pkg;

  localparam int FRAME_LEN = 80;
  localparam int ADDR_W    = 7;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CLR   = 4'd1,
    ST_READ  = 4'd2,
    ST_LATCH = 4'd3,
    ST_MAC0  = 4'd4,
    ST_MAC1  = 4'd5,
    ST_MAC2  = 4'd6,
    ST_MAC3  = 4'd7,
    ST_MAC4  = 4'd8,
    ST_UPD   = 4'd9,
    ST_WR    = 4'd10,
    ST_DONE  = 4'd11
  } state_t;

  localparam logic [2:0] OP_B0 = 3'd0;
  localparam logic [2:0] OP_B1 = 3'd1;
  localparam logic [2:0] OP_B2 = 3'd2;
  localparam logic [2:0] OP_A1 = 3'd3;
  localparam logic [2:0] OP_A2 = 3'd4;

endpackage

`default_nettype wire

// File: rtl/pre_proc_hpf_ctrl_sample_counter.sv
// +----------------------------------------------------------------------------+
// | sample_counter : frame sample index with clear, increment and terminal flag |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module sample_counter #(
  parameter int FRAME_LEN = 80,
  parameter int ADDR_W    = 7
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_cnt,
  output logic              o_tc
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(FRAME_LEN - 1);

  logic [ADDR_W-1:0] r_cnt;

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/pre_proc_hpf_ctrl.sv
// +----------------------------------------------------------------------------+
// | pre_proc_hpf_ctrl : sequences one frame through the shared MAC datapath     |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module pre_proc_hpf_ctrl #(
  parameter int FRAME_LEN = pre_proc_pkg::FRAME_LEN,
  parameter int ADDR_W    = pre_proc_pkg::ADDR_W
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              start,
  input  logic              init,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [2:0]        op_sel,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              ld_x0,
  output logic              ld_x1,
  output logic              ld_x2,
  output logic              ld_y1,
  output logic              ld_y2,
  output logic              clr_state
);

  import pre_proc_pkg::*;

  state_t r_state;
  state_t w_next;
  logic   w_cnt_clr;
  logic   w_cnt_inc;
  logic   w_cnt_tc;

  sample_counter #(
    .FRAME_LEN (FRAME_LEN),
    .ADDR_W    (ADDR_W)
  ) u_cnt (
    .mclk  (mclk),
    .reset (reset),
    .i_clr (w_cnt_clr),
    .i_inc (w_cnt_inc),
    .o_cnt (mem_addr),
    .o_tc  (w_cnt_tc)
  );

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    done      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    op_sel    = OP_B0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    ld_x0     = 1'b0;
    ld_x1     = 1'b0;
    ld_x2     = 1'b0;
    ld_y1     = 1'b0;
    ld_y2     = 1'b0;
    clr_state = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // init wins over a simultaneous start; the start is dropped
        if (init) begin
          w_next = ST_CLR;
        end else if (start) begin
          w_next    = ST_READ;
          w_cnt_clr = 1'b1;
        end
      end
      ST_CLR: begin
        clr_state = 1'b1;
        w_next    = ST_DONE;
      end
      ST_READ: begin
        mem_rd = 1'b1;
        w_next = ST_LATCH;
      end
      ST_LATCH: begin
        ld_x0  = 1'b1;
        w_next = ST_MAC0;
      end
      ST_MAC0: begin
        op_sel  = OP_B0;
        acc_clr = 1'b1;
        w_next  = ST_MAC1;
      end
      ST_MAC1: begin
        op_sel = OP_B1;
        acc_en = 1'b1;
        w_next = ST_MAC2;
      end
      ST_MAC2: begin
        op_sel = OP_B2;
        acc_en = 1'b1;
        w_next = ST_MAC3;
      end
      ST_MAC3: begin
        op_sel = OP_A1;
        acc_en = 1'b1;
        w_next = ST_MAC4;
      end
      ST_MAC4: begin
        op_sel = OP_A2;
        acc_en = 1'b1;
        w_next = ST_UPD;
      end
      ST_UPD: begin
        // delay-line shift: each register takes its neighbour's pre-edge value
        ld_x1  = 1'b1;
        ld_x2  = 1'b1;
        ld_y1  = 1'b1;
        ld_y2  = 1'b1;
        w_next = ST_WR;
      end
      ST_WR: begin
        mem_wr = 1'b1;
        if (w_cnt_tc) begin
          w_next = ST_DONE;
        end else begin
          w_cnt_inc = 1'b1;
          w_next    = ST_READ;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        w_cnt_clr = 1'b1;
        w_next    = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/pre_proc_hpf_ctrl.md
# pre_proc_hpf_ctrl

Sequencing controller for the G.729 pre-processing high-pass filter (the 140 Hz, 2nd-order IIR). It walks one 80-sample speech frame through the shared Q31 multiply-accumulate datapath. It drives the speech buffer address and read/write strobes, the coefficient/operand select, the accumulator controls, and the load enables of the filter-state registers (x0, x1, x2, y1, y2). It also sequences the Init_Pre_Process state clear.

## Interface
- FRAME_LEN, 80, samples per frame
- ADDR_W, 7, speech buffer address width (must satisfy 2^ADDR_W >= FRAME_LEN)
- mclk  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears FSM, counter and all outputs
- start  in  1  begin filtering one frame; sampled only in IDLE
- init  in  1  request filter-state clear; sampled only in IDLE; priority over start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when frame (or init clear) completes
- mem_addr  out  ADDR_W  speech buffer sample index
- mem_rd  out  1  buffer read strobe; data valid on the following cycle
- mem_wr  out  1  buffer write strobe (filtered sample to mem_addr)
- op_sel  out  3  MAC operand select: 0=b0·x0, 1=b1·x1, 2=b2·x2, 3=a1·y1, 4=a2·y2
- acc_clr  out  1  clear accumulator to 0 this cycle (load first product)
- acc_en  out  1  accumulate selected product this cycle
- ld_x0, ld_x1, ld_x2, ld_y1, ld_y2  out  1 each  state-register load enables
- clr_state  out  1  synchronous clear of all five state registers

## Operation
- States: IDLE, CLR, READ, LATCH, MAC0, MAC1, MAC2, MAC3, MAC4, UPD, WR, DONE.
- Moore outputs are decoded from the registered state. Every output is 0 in IDLE and at reset. mem_addr equals the sample counter `cnt`, which resets to 0.
- IDLE:
  - init=1 → CLR.
  - Otherwise start=1 → READ with cnt=0.
  - Otherwise stay in IDLE.
- CLR: clr_state=1 → DONE.
- READ: mem_rd=1 → LATCH.
- LATCH: ld_x0=1 (captures buffer data) → MAC0.
- MACn (n=0..4): op_sel=n.
  - acc_clr=1 in MAC0 only.
  - acc_en=1 in MAC1..MAC4.
- UPD: ld_y2, ld_y1, ld_x2, ld_x1 all =1 in the same cycle. The datapath wires y2←y1, y1←acc, x2←x1, x1←x0, so every register loads its pre-edge neighbour value.
- WR: mem_wr=1, writing the rounded accumulator to mem_addr (in-place filtering).
  - If cnt==FRAME_LEN-1 → DONE.
  - Otherwise cnt←cnt+1 → READ.
- DONE: done=1 → IDLE. cnt←0.
- Arithmetic (saturation, rounding, Q formats) lives in the datapath. The controller only sequences it.
- start or init asserted while busy: ignored, not queued.
- init and start both high in IDLE: init serviced, start dropped.
- Reset mid-frame: immediate return to IDLE with all outputs 0 and cnt=0. Buffer contents are left partially filtered; state registers are cleared by their own reset.

## Timing
- Per sample: 9 cycles (READ through WR).
- Frame: start sampled at edge k → READ in cycle k+1 → done high in cycle k+1+9·FRAME_LEN (k+721 for 80 samples). busy falls in the cycle after done.
- Init: init sampled at edge k → clr_state in cycle k+1 → done in cycle k+2.
- Back-to-back: a start seen in the first IDLE cycle after DONE begins the next frame. Frame-to-frame gap is 1 idle cycle.
- mem_addr is stable across READ..WR for one sample and changes only on the WR→READ edge.
- No two of mem_rd, mem_wr, ld_* or clr_state are high in the same cycle, except the four UPD loads.

## Structure
- Shared package pre_proc_pkg:
  - state enumeration (4-bit encoding)
  - op_sel codes OP_B0..OP_A2
  - FRAME_LEN constant (shared with the buffer and the datapath)
- One sub-module is natural: `sample_counter`, a loadable ADDR_W counter with clear, increment and terminal-count flag (cnt==FRAME_LEN-1).
- The FSM and output decode stay in the top module.

## Test plan
- Reset: assert reset mid-MAC2 of sample 37 → same cycle all outputs 0, busy=0; next start restarts at mem_addr=0.
- Full frame: pulse start with FRAME_LEN=80 → exactly 80 mem_rd and 80 mem_wr pulses; addresses 0..79 in order; done 721 cycles after start; with a golden datapath the buffer matches the C reference Pre_Process output.
- Per-sample sequence: check the cycle-exact pattern READ, LATCH, op_sel 0,1,2,3,4 (acc_clr only with 0), UPD with four loads, WR.
- Init: pulse init → clr_state in the next cycle, done in the one after, no memory strobes; init+start together → same result, no frame processed.
- Ignored requests: pulse start and init at sample 10 of a running frame → frame timing unchanged, single done.
- Back-to-back: hold start high → frames separated by exactly 1 IDLE cycle; second frame mem_addr begins at 0.
